// File: rtl/io_port_ctrl.sv
// io_port_ctrl: OUTPUT/INPUT instruction port handshake with pipeline stall.
// Define IO_PORT_TIMEOUT_EN to abort strobes that see no acknowledge.
`timescale 1ns/1ps
module io_port_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_wr_req,
    input  logic       io_rd_req,
    input  logic [7:0] io_port_id,
    input  logic [7:0] io_wr_data,
    input  logic [7:0] in_port,
    input  logic       io_ack,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    output logic       stall,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       io_err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t     state;
    logic       pend_rd;
    logic [7:0] pend_port;
    logic       abort;
    logic       finish;

`ifdef IO_PORT_TIMEOUT_EN
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt;
    logic       err_q;

    // Acknowledge takes priority over an expiring counter.
    assign abort  = !io_ack && (cnt == LAST);
    assign io_err = err_q;
`else
    assign abort  = 1'b0;
    assign io_err = 1'b0;
`endif

    assign finish = io_ack || abort;

    assign stall = ((state != IDLE) && (state != DONE))
                || ((state == IDLE) && (io_wr_req || io_rd_req))
                || ((state == DONE) && pend_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pend_rd      <= 1'b0;
            pend_port    <= 8'h00;
            port_id      <= 8'h00;
            out_port     <= 8'h00;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            rd_data      <= 8'h00;
            rd_valid     <= 1'b0;
`ifdef IO_PORT_TIMEOUT_EN
            cnt          <= 8'h00;
            err_q        <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
`ifdef IO_PORT_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (io_wr_req) begin
                        state        <= WRITE;
                        write_strobe <= 1'b1;
                        port_id      <= io_port_id;
                        out_port     <= io_wr_data;
                        pend_rd      <= io_rd_req;
                        pend_port    <= io_port_id;
`ifdef IO_PORT_TIMEOUT_EN
                        cnt          <= 8'h00;
`endif
                    end else if (io_rd_req) begin
                        state       <= READ;
                        read_strobe <= 1'b1;
                        port_id     <= io_port_id;
`ifdef IO_PORT_TIMEOUT_EN
                        cnt         <= 8'h00;
`endif
                    end
                end
                WRITE: begin
                    if (finish) begin
                        state        <= DONE;
                        write_strobe <= 1'b0;
`ifdef IO_PORT_TIMEOUT_EN
                        err_q        <= abort;
                    end else begin
                        cnt          <= cnt + 8'd1;
`endif
                    end
                end
                READ: begin
                    if (finish) begin
                        state       <= DONE;
                        read_strobe <= 1'b0;
                        rd_valid    <= 1'b1;
                        rd_data     <= abort ? 8'h00 : in_port;
`ifdef IO_PORT_TIMEOUT_EN
                        err_q       <= abort;
                    end else begin
                        cnt         <= cnt + 8'd1;
`endif
                    end
                end
                DONE: begin
                    if (pend_rd) begin
                        state       <= READ;
                        read_strobe <= 1'b1;
                        pend_rd     <= 1'b0;
                        port_id     <= pend_port;
`ifdef IO_PORT_TIMEOUT_EN
                        cnt         <= 8'h00;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: table-driven transactions plus reset and no-ack sequences.
// Timeout vectors are added when IO_PORT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_io_port_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       io_wr_req = 1'b0;
    logic       io_rd_req = 1'b0;
    logic [7:0] io_port_id = 8'h00;
    logic [7:0] io_wr_data = 8'h00;
    logic [7:0] in_port = 8'h00;
    logic       io_ack = 1'b0;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       stall;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       io_err;

    int pass_cnt = 0;
    int total = 0;

    io_port_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_wr_req    (io_wr_req),
        .io_rd_req    (io_rd_req),
        .io_port_id   (io_port_id),
        .io_wr_data   (io_wr_data),
        .in_port      (in_port),
        .io_ack       (io_ack),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .stall        (stall),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .io_err       (io_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] port;
        logic [7:0] wdata;
        logic [7:0] din;
        int         ack_at;
        int         e_stall;
        int         e_wstb;
        int         e_rstb;
        int         e_valid;
        int         e_err;
        logic [7:0] e_rd;
        logic [7:0] e_port;
        logic [7:0] e_out;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic rd,
                                input logic [7:0] port, input logic [7:0] wdata,
                                input logic [7:0] din, input int ack_at,
                                input int e_stall, input int e_wstb,
                                input int e_rstb, input int e_valid,
                                input int e_err, input logic [7:0] e_rd,
                                input logic [7:0] e_port, input logic [7:0] e_out);
        vec_t v;
        v.wr = wr; v.rd = rd; v.port = port; v.wdata = wdata; v.din = din;
        v.ack_at = ack_at; v.e_stall = e_stall; v.e_wstb = e_wstb;
        v.e_rstb = e_rstb; v.e_valid = e_valid; v.e_err = e_err;
        v.e_rd = e_rd; v.e_port = e_port; v.e_out = e_out;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Requests stay high until the cycle stall drops, like a held pipeline.
    // ack_at counts strobe cycles within each strobe phase; 0 means never.
    task automatic run_vec(input vec_t v, input int idx);
        int ns = 0, nw = 0, nr = 0, nv = 0, ne = 0, ph = 0;
        logic [7:0] cap = 8'h00;
        bit fin = 1'b0;
        string tag;
        tag = $sformatf("v%0d", idx);
        io_wr_req  = v.wr;
        io_rd_req  = v.rd;
        io_port_id = v.port;
        io_wr_data = v.wdata;
        for (int c = 0; c < 40 && !fin; c++) begin
            io_ack  = (write_strobe || read_strobe) && (ph + 1 == v.ack_at);
            in_port = io_ack ? v.din : ~v.din;
            #1;
            if (stall) ns++;
            if (write_strobe) nw++;
            if (read_strobe) nr++;
            if (rd_valid) begin nv++; cap = rd_data; end
            if (io_err) ne++;
            ph = (write_strobe || read_strobe) ? ph + 1 : 0;
            if (!stall && (nw + nr) > 0) fin = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
        check({tag, "_stall_cyc"}, 32'(ns), 32'(v.e_stall));
        check({tag, "_wstb_cyc"}, 32'(nw), 32'(v.e_wstb));
        check({tag, "_rstb_cyc"}, 32'(nr), 32'(v.e_rstb));
        check({tag, "_rd_valid"}, 32'(nv), 32'(v.e_valid));
        check({tag, "_io_err"}, 32'(ne), 32'(v.e_err));
        check({tag, "_rd_data"}, 32'(cap), 32'(v.e_rd));
        check({tag, "_port_id"}, 32'(port_id), 32'(v.e_port));
        check({tag, "_out_port"}, 32'(out_port), 32'(v.e_out));
        io_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        io_wr_req = 1'b0;
        io_rd_req = 1'b0;
        #1;
        check({tag, "_idle_strobes"}, 32'({write_strobe, read_strobe}), 32'd0);
        check({tag, "_idle_stall"}, 32'(stall), 32'd0);
        check({tag, "_hold_port"}, 32'(port_id), 32'(v.e_port));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv, nstb, nerr;

        vecs.push_back(mk(1, 0, 8'h12, 8'hA5, 8'h00, 1, 2, 1, 0, 0, 0, 8'h00, 8'h12, 8'hA5));
        vecs.push_back(mk(0, 1, 8'h30, 8'h00, 8'h5C, 3, 4, 0, 3, 1, 0, 8'h5C, 8'h30, 8'hA5));
        vecs.push_back(mk(1, 1, 8'h44, 8'h3C, 8'h99, 1, 4, 1, 1, 1, 0, 8'h99, 8'h44, 8'h3C));
        vecs.push_back(mk(1, 0, 8'hFF, 8'h00, 8'h00, 2, 3, 2, 0, 0, 0, 8'h00, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 1, 8'h00, 8'h55, 8'hFF, 1, 2, 0, 1, 1, 0, 8'hFF, 8'h00, 8'h00));
        vecs.push_back(mk(1, 1, 8'h81, 8'h7E, 8'h18, 2, 6, 2, 2, 1, 0, 8'h18, 8'h81, 8'h7E));
`ifdef IO_PORT_TIMEOUT_EN
        vecs.push_back(mk(0, 1, 8'h66, 8'h00, 8'hEE, 0, 5, 0, 4, 1, 1, 8'h00, 8'h66, 8'h7E));
        vecs.push_back(mk(1, 0, 8'h77, 8'h11, 8'h00, 0, 5, 4, 0, 0, 1, 8'h00, 8'h77, 8'h11));
        vecs.push_back(mk(0, 1, 8'h0F, 8'h00, 8'h42, 4, 5, 0, 4, 1, 0, 8'h42, 8'h0F, 8'h11));
`endif

        // Reset state
        #3;
        check("rst_regs", {port_id, out_port, rd_data, write_strobe,
                           read_strobe, rd_valid, io_err}, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        io_rd_req = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold", 32'({read_strobe, port_id}), 32'd0);
        io_rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset during the second read strobe cycle
        io_rd_req  = 1'b1;
        io_port_id = 8'h5A;
        io_ack     = 1'b0;
        in_port    = 8'h00;
        @(negedge clk);
        #1;
        check("mid_strobe1", 32'(read_strobe), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_regs", {port_id, out_port, rd_data, write_strobe,
                               read_strobe, rd_valid, io_err}, 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd1);
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (rd_valid || io_err) nv++;
        end
        check("mid_rst_no_pulse", 32'(nv), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_accept_stb", 32'(read_strobe), 32'd1);
        check("mid_accept_port", 32'(port_id), 32'h5A);
        io_ack  = 1'b1;
        in_port = 8'hC3;
        @(negedge clk);
        io_ack = 1'b0;
        #1;
        check("mid_done_valid", 32'(rd_valid), 32'd1);
        check("mid_done_data", 32'(rd_data), 32'hC3);
        io_rd_req = 1'b0;
        @(negedge clk);
        #1;
        check("mid_idle", 32'({stall, read_strobe, rd_valid}), 32'd0);

`ifndef IO_PORT_TIMEOUT_EN
        // Without timeout the strobe waits for acknowledge indefinitely
        io_rd_req  = 1'b1;
        io_port_id = 8'h24;
        in_port    = 8'h00;
        @(negedge clk);
        nstb = 0;
        nerr = 0;
        repeat (30) begin
            #1;
            if (read_strobe) nstb++;
            if (io_err || rd_valid) nerr++;
            @(negedge clk);
        end
        check("noack_strobe_cyc", 32'(nstb), 32'd30);
        check("noack_no_err", 32'(nerr), 32'd0);
        check("noack_stall", 32'(stall), 32'd1);
        io_ack  = 1'b1;
        in_port = 8'h6D;
        @(negedge clk);
        io_ack = 1'b0;
        #1;
        check("noack_late_valid", 32'({rd_valid, io_err}), 32'b10);
        check("noack_late_data", 32'(rd_data), 32'h6D);
        io_rd_req = 1'b0;
        @(negedge clk);
`else
        nstb = 0;
        nerr = 0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
